// File: rtl/clk_otp_div_gen_pkg.sv
// Shared types and defaults for the 100 kHz OFF/TOGGLE/DIV/ONESHOT output generator.
package clk_otp_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_TOGGLE  = 2'b01,
        MODE_DIV     = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DIV_W  = 8;

    // Channel-index width; a single channel still needs a 1-bit select.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_otp_div_gen_if.sv
// Configuration request bus: the master issues channel/mode/div, the generator answers ready/err.
interface clk_otp_div_gen_if
    import clk_otp_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIV_W  = DEF_DIV_W
);
    localparam int CH_W = ch_w(NUM_CH);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    mode_e            cfg_mode;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_mode, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_mode, cfg_div,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/clk_otp_div_gen_ch.sv
// One output channel: mode register, non-wrapping counter, registered out and busy.
module clk_otp_div_ch
    import clk_otp_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  mode_e            mode_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             out_o,
    output logic             busy_o
);

    mode_e            mode_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             out_q;
    logic             busy_q;

    assign cnt_d  = cnt_q + 1'b1;
    assign out_o  = out_q;
    assign busy_o = busy_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_OFF;
            div_q  <= '0;
            cnt_q  <= '0;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
        end else if (load_i) begin
            // A load overrides whatever is in flight, including an active one-shot.
            mode_q <= mode_i;
            div_q  <= div_i;
            cnt_q  <= '0;
            out_q  <= (mode_i == MODE_ONESHOT);
            busy_q <= (mode_i == MODE_ONESHOT);
        end else begin
            unique case (mode_q)
                MODE_OFF: begin
                    out_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
                MODE_TOGGLE: out_q <= ~out_q;
                MODE_DIV: begin
                    if (cnt_q == div_q) begin
                        out_q <= 1'b1;
                        cnt_q <= '0;
                    end else begin
                        out_q <= 1'b0;
                        cnt_q <= cnt_d;
                    end
                end
                MODE_ONESHOT: begin
                    if (cnt_q == div_q) begin
                        out_q  <= 1'b0;
                        busy_q <= 1'b0;
                        cnt_q  <= '0;
                        mode_q <= MODE_OFF;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: mode_q <= MODE_OFF;
            endcase
        end
    end

endmodule

// File: rtl/clk_otp_div_gen.sv
// Multi-channel clock/one-shot generator: config handshake and channel decode around NUM_CH channels.
module clk_otp_div_gen
    import clk_otp_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic              clk_osc_100k,
    input  logic              soft_reset,
    clk_otp_div_gen_if.slave  cfg,
    output logic [NUM_CH-1:0] out,
    output logic [NUM_CH-1:0] busy
);

    localparam int CH_W = ch_w(NUM_CH);

    logic ready_q;
    logic err_q;
    logic accept;
    logic ch_ok;

    assign accept        = cfg.cfg_valid && ready_q && !soft_reset;
    assign ch_ok         = int'({1'b0, cfg.cfg_ch}) < NUM_CH;
    assign cfg.cfg_ready = ready_q;
    assign cfg.cfg_err   = err_q;

    always_ff @(posedge clk_osc_100k) begin
        if (soft_reset) begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            err_q   <= accept && !ch_ok;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic load;
        assign load = accept && ch_ok && (cfg.cfg_ch == CH_W'(g));

        clk_otp_div_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk_i  (clk_osc_100k),
            .rst_i  (soft_reset),
            .load_i (load),
            .mode_i (cfg.cfg_mode),
            .div_i  (cfg.cfg_div),
            .out_o  (out[g]),
            .busy_o (busy[g])
        );
    end

endmodule

// File: tb/tb_clk_otp_div_gen.sv
// Random and directed stimulus on a 4-channel and a 3-channel generator, checked against a timing model.
module tb_clk_otp_div_gen;
    import clk_otp_pkg::*;

    logic       clk = 1'b0;
    logic       soft_reset;
    logic [3:0] out0, busy0;
    logic [2:0] out1, busy1;

    int n_checks = 0;
    int n_errors = 0;

    clk_otp_div_gen_if #(.NUM_CH(4), .DIV_W(8)) if0 ();
    clk_otp_div_gen_if #(.NUM_CH(3), .DIV_W(8)) if1 ();

    clk_otp_div_gen #(.NUM_CH(4), .DIV_W(8)) u_dut0 (
        .clk_osc_100k (clk),
        .soft_reset   (soft_reset),
        .cfg          (if0.slave),
        .out          (out0),
        .busy         (busy0)
    );

    clk_otp_div_gen #(.NUM_CH(3), .DIV_W(8)) u_dut1 (
        .clk_osc_100k (clk),
        .soft_reset   (soft_reset),
        .cfg          (if1.slave),
        .out          (out1),
        .busy         (busy1)
    );

    always #5 clk = ~clk;

    // Model: per channel the mode, the div value and the number of edges since it was configured.
    int nch[2] = '{4, 3};
    int md[2][4];
    int dd[2][4];
    int tt[2][4];
    bit rst_prev = 1'b1;
    bit err_exp[2];
    bit rdy_exp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_out(input int k, input int c);
        case (md[k][c])
            1:       return (tt[k][c] % 2) == 1;
            2:       return (tt[k][c] > 0) && ((tt[k][c] % (dd[k][c] + 1)) == 0);
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge(input bit rst, input bit v, input int ch, input int m, input int dv);
        bit acc;
        acc = v && !rst_prev && !rst;
        for (int k = 0; k < 2; k++) begin
            err_exp[k] = acc && (ch >= nch[k]);
            for (int c = 0; c < nch[k]; c++) begin
                if (rst) begin
                    md[k][c] = 0;
                    tt[k][c] = 0;
                end else if (acc && ch == c) begin
                    md[k][c] = m;
                    dd[k][c] = dv;
                    tt[k][c] = 0;
                end else begin
                    tt[k][c]++;
                    if (md[k][c] == 3 && tt[k][c] > dd[k][c]) md[k][c] = 0;
                end
            end
        end
        rst_prev = rst;
        rdy_exp  = !rst;
    endtask

    task automatic compare();
        logic [3:0] oe0, be0;
        logic [2:0] oe1, be1;
        for (int c = 0; c < 4; c++) begin
            oe0[c] = exp_out(0, c);
            be0[c] = (md[0][c] == 3);
        end
        for (int c = 0; c < 3; c++) begin
            oe1[c] = exp_out(1, c);
            be1[c] = (md[1][c] == 3);
        end
        check("dut0.out",   32'(out0),  32'(oe0));
        check("dut0.busy",  32'(busy0), 32'(be0));
        check("dut0.ready", 32'(if0.cfg_ready), 32'(rdy_exp));
        check("dut0.err",   32'(if0.cfg_err),   32'(err_exp[0]));
        check("dut1.out",   32'(out1),  32'(oe1));
        check("dut1.busy",  32'(busy1), 32'(be1));
        check("dut1.ready", 32'(if1.cfg_ready), 32'(rdy_exp));
        check("dut1.err",   32'(if1.cfg_err),   32'(err_exp[1]));
    endtask

    task automatic step(input bit rst, input bit v, input int ch, input int m, input int dv);
        logic [1:0] ch2;
        logic [1:0] m2;
        logic [7:0] dv8;
        ch2 = 2'(ch);
        m2  = 2'(m);
        dv8 = 8'(dv);
        soft_reset    = rst;
        if0.cfg_valid = v;
        if0.cfg_ch    = ch2;
        if0.cfg_mode  = mode_e'(m2);
        if0.cfg_div   = dv8;
        if1.cfg_valid = v;
        if1.cfg_ch    = ch2;
        if1.cfg_mode  = mode_e'(m2);
        if1.cfg_div   = dv8;
        @(posedge clk);
        model_edge(rst, v, int'(ch2), int'(m2), int'(dv8));
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++) begin
                md[k][c] = 0;
                dd[k][c] = 0;
                tt[k][c] = 0;
            end

        // Reset held three cycles with a pending request, then release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1, 2, 3);
        idle(1);

        // ch1 DIV div=3
        step(1'b0, 1'b1, 1, 2, 3);
        idle(12);

        // ch2 ONESHOT div=5
        step(1'b0, 1'b1, 2, 3, 5);
        idle(8);

        // ch0 ONESHOT div=10 overridden by TOGGLE three cycles later
        step(1'b0, 1'b1, 0, 3, 10);
        idle(2);
        step(1'b0, 1'b1, 0, 1, 0);
        idle(4);

        // Out-of-range channel on the 3-channel instance
        step(1'b0, 1'b1, 3, 2, 1);
        idle(3);

        // Reset in the middle of DIV and ONESHOT
        step(1'b0, 1'b1, 1, 2, 3);
        step(1'b0, 1'b1, 2, 3, 5);
        idle(2);
        step(1'b1, 1'b0, 0, 0, 0);
        idle(8);

        // DIV div=0 boundary
        step(1'b0, 1'b1, 3, 2, 0);
        idle(4);

        for (int i = 0; i < 600; i++) begin
            bit rst, v;
            int ch, m, dv;
            rst = ($urandom_range(0, 49) == 0);
            v   = ($urandom_range(0, 2) == 0);
            ch  = int'($urandom_range(0, 3));
            m   = int'($urandom_range(0, 3));
            dv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 5));
            step(rst, v, ch, m, dv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_otp_div_gen.md
CLK_OTP_DIV_GEN -- requirements
Module: clk_otp_div_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent output channels, range 1..16.
REQ-002 Parameter DIV_W, default 8: width of the per-channel divide/length value.
REQ-003 clk_osc_100k  input  1  100 kHz oscillator clock; the only clock.
REQ-004 soft_reset  input  1  synchronous, active-high reset.
REQ-005 cfg_valid  input  1  configuration request valid.
REQ-006 cfg_ready  output  1  block can accept a configuration.
REQ-007 cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel index.
REQ-008 cfg_mode  input  2  requested mode: 00 OFF, 01 TOGGLE, 10 DIV, 11 ONESHOT.
REQ-009 cfg_div  input  DIV_W  divide value (DIV) or pulse length minus 1 (ONESHOT).
REQ-010 out  output  NUM_CH  per-channel registered output.
REQ-011 busy  output  NUM_CH  per-channel ONESHOT in progress.
REQ-012 cfg_err  output  1  one-cycle pulse on a rejected configuration.

Function
REQ-013 All outputs SHALL be registered; there is no combinational path from inputs to out or busy.
REQ-014 A configuration is accepted on a rising edge where cfg_valid and cfg_ready are both 1.
REQ-015 cfg_ready SHALL be 1 on every cycle where soft_reset was 0 at the previous edge; there is no back-pressure otherwise.
REQ-016 At the accepting edge, the selected channel SHALL load mode and div, clear its counter to 0, and set out per REQ-017..020.
REQ-017 OFF: out <= 0 at the accepting edge, then out holds 0; busy is 0.
REQ-018 TOGGLE: out <= 0 at the accepting edge, then out inverts on every edge (period = 2 cycles).
REQ-019 DIV: out <= 0 at the accepting edge; counter increments each edge; when counter == cfg_div, out <= 1 for one cycle and counter <= 0.
- div=3: first pulse 4 edges after accept, then every 4 cycles.
- div=0: out is 1 on every cycle after the accepting edge.
REQ-020 ONESHOT: out <= 1 and busy <= 1 at the accepting edge; counter increments each edge; on the edge where counter == cfg_div, out <= 0, busy <= 0 and the mode returns to OFF.
- out is high for exactly cfg_div+1 cycles.
REQ-021 The counter is DIV_W bits wide and SHALL never wrap; it is reloaded to 0 at its terminal value.
REQ-022 A new configuration to a channel mid-operation SHALL override immediately (including an active ONESHOT); no residual pulse SHALL occur.
REQ-023 cfg_ch >= NUM_CH: the configuration is ignored, no channel state changes, and cfg_err <= 1 for one cycle.
REQ-024 Channels are independent; a configuration to one channel SHALL NOT disturb the phase or counter of another.

Reset
REQ-025 While soft_reset=1 at an edge, every channel SHALL be set to mode OFF, counter 0, out 0 and busy 0; cfg_err=0 and cfg_ready=0.
REQ-026 Reset SHALL take priority over a simultaneous configuration; cfg_valid is ignored during reset.
REQ-027 Reset asserted mid-ONESHOT or mid-DIV SHALL terminate the operation at that edge with no further pulse.

Structure
REQ-028 Package clk_otp_pkg SHALL hold the 2-bit mode enum typedef (OFF, TOGGLE, DIV, ONESHOT) and the default NUM_CH and DIV_W constants.
REQ-029 Per-channel logic SHALL be the sub-module clk_otp_div_ch (mode register, counter, out, busy), instantiated NUM_CH times by generate; the top holds only the handshake, decode and cfg_err logic.

Verification
REQ-030 Reset: hold soft_reset=1 for 3 cycles with cfg_valid=1 -> out=0, busy=0, cfg_ready=0; cfg_ready=1 on the first cycle after release.
REQ-031 DIV: configure ch1 with DIV, div=3 -> out[1] pulses one cycle every 4 cycles, first pulse 4 edges after accept; out[0], out[2] and out[3] stay 0.
REQ-032 ONESHOT: configure ch2 with ONESHOT, div=5 -> out[2] and busy[2] high for exactly 6 cycles, then ch2 is OFF.
REQ-033 Override: start ONESHOT div=10 on ch0, then 3 cycles later configure ch0 as TOGGLE -> busy[0] drops at that edge and out[0] toggles from 0.
REQ-034 Error: NUM_CH=3, cfg_ch=3 -> cfg_err pulses for exactly 1 cycle and all channel outputs are unchanged.
REQ-035 Reset mid-op: assert soft_reset during ch1 DIV and ch2 ONESHOT -> out and busy are 0 at that edge with no later pulses.
